// File: rtl/rf_pkg.sv
// rf_pkg: shared constants and FSM state type for the multi-port register file.
//   RF_DW      default data width
//   RF_DEPTH   default number of entries
//   rf_state_e clear-sequencer state (RF_IDLE, RF_CLEAR)
package rf_pkg;

    localparam int unsigned RF_DW    = 32;
    localparam int unsigned RF_DEPTH = 32;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

endpackage

// File: rtl/rf_rd_mux.sv
// rf_rd_mux: one combinational read port of the register file.
// Applies the zero-register rule, masks data while the clear sweep runs and,
// when RF_BYPASS_EN is defined and BYP_EN!=0, forwards same-cycle write data
// (highest write port wins).
// Ports:
//   ra    read address
//   row   stored entry selected by ra
//   busy  clear sweep active; forces rd to 0
//   wa/we/wd  write-port buses used for the bypass compare
//   rd    read data
module rf_rd_mux #(
    parameter int unsigned DW       = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned NW       = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYP_EN   = 1
) (
    input  logic [AW-1:0]    ra,
    input  logic [DW-1:0]    row,
    input  logic             busy,
    input  logic [NW*AW-1:0] wa,
    input  logic [NW-1:0]    we,
    input  logic [NW*DW-1:0] wd,
    output logic [DW-1:0]    rd
);

    logic is_zero;
    logic unused_byp;

    assign is_zero    = (ZERO_REG != 0) && (ra == '0);
    // Write buses only feed the bypass compare; keep them referenced otherwise.
    assign unused_byp = ^{wa, we, wd};

`ifdef RF_BYPASS_EN
    // Later write ports override earlier ones, matching the array priority.
    always_comb begin
        rd = row;
        if (BYP_EN != 0) begin
            for (int j = 0; j < int'(NW); j++) begin
                if (we[j] && (wa[j*AW +: AW] == ra)) begin
                    rd = wd[j*DW +: DW];
                end
            end
        end
        if (busy || is_zero) begin
            rd = '0;
        end
    end
`else
    always_comb begin
        rd = row;
        if (busy || is_zero) begin
            rd = '0;
        end
    end
`endif

endmodule

// File: rtl/rf_mp.sv
// rf_mp: parametrised multi-port register file with hardware clear sequencer.
// Optional same-cycle write-to-read bypass is built when RF_BYPASS_EN is defined.
// Ports:
//   clk, rst    clock and asynchronous active-high reset
//   clr_req     pulse that starts a full clear sweep (ignored while sweeping)
//   busy        high while the clear sweep runs; reads return 0
//   rf_ra/rf_rd NR read ports, combinational
//   rf_wa/rf_we/rf_wd  NW write ports, higher index wins on conflict
//   dbg_reg_ra/dbg_reg_rd  debug read port, never bypassed
module rf_mp
    import rf_pkg::*;
#(
    parameter int unsigned DW       = RF_DW,
    parameter int unsigned DEPTH    = RF_DEPTH,
    parameter int unsigned AW       = $clog2(DEPTH),
    parameter int unsigned NR       = 2,
    parameter int unsigned NW       = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_req,
    output logic             busy,
    input  logic [NR*AW-1:0] rf_ra,
    output logic [NR*DW-1:0] rf_rd,
    input  logic [NW*AW-1:0] rf_wa,
    input  logic [NW-1:0]    rf_we,
    input  logic [NW*DW-1:0] rf_wd,
    input  logic [AW-1:0]    dbg_reg_ra,
    output logic [DW-1:0]    dbg_reg_rd
);

    rf_state_e     state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];

    assign busy = (state_q == RF_CLEAR);

    // Clear sequencer and write port logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        mem_d   = mem_q;
        case (state_q)
            RF_IDLE: begin
                for (int j = 0; j < int'(NW); j++) begin
                    if (rf_we[j] && !((ZERO_REG != 0) && (rf_wa[j*AW +: AW] == '0))) begin
                        mem_d[rf_wa[j*AW +: AW]] = rf_wd[j*DW +: DW];
                    end
                end
                if (clr_req) begin
                    state_d = RF_CLEAR;
                    ptr_d   = '0;
                end
            end
            RF_CLEAR: begin
                mem_d[ptr_q] = '0;
                ptr_d        = ptr_q + AW'(1);
                if (ptr_q == AW'(DEPTH - 1)) begin
                    state_d = RF_IDLE;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = RF_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    // Sequencer state; reset restarts the sweep from entry 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RF_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Storage array has no reset; the sweep clears it after rst falls.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q <= mem_d;
        end
    end

    // Functional read ports.
    for (genvar k = 0; k < int'(NR); k++) begin : g_rd
        rf_rd_mux #(
            .DW       (DW),
            .AW       (AW),
            .NW       (NW),
            .ZERO_REG (ZERO_REG),
            .BYP_EN   (1)
        ) u_rd (
            .ra   (rf_ra[k*AW +: AW]),
            .row  (mem_q[rf_ra[k*AW +: AW]]),
            .busy (busy),
            .wa   (rf_wa),
            .we   (rf_we),
            .wd   (rf_wd),
            .rd   (rf_rd[k*DW +: DW])
        );
    end

    // Debug port shows committed state only, so its bypass inputs are tied off.
    rf_rd_mux #(
        .DW       (DW),
        .AW       (AW),
        .NW       (NW),
        .ZERO_REG (ZERO_REG),
        .BYP_EN   (0)
    ) u_dbg (
        .ra   (dbg_reg_ra),
        .row  (mem_q[dbg_reg_ra]),
        .busy (busy),
        .wa   ('0),
        .we   ('0),
        .wd   ('0),
        .rd   (dbg_reg_rd)
    );

endmodule

// File: tb/tb_rf_mp.sv
// tb_rf_mp: directed, table-driven bench for rf_mp at default parameters.
module tb_rf_mp;

    logic        clk;
    logic        rst;
    logic        clr_req;
    logic        busy;
    logic [9:0]  rf_ra;
    logic [63:0] rf_rd;
    logic [9:0]  rf_wa;
    logic [1:0]  rf_we;
    logic [63:0] rf_wd;
    logic [4:0]  dbg_reg_ra;
    logic [31:0] dbg_reg_rd;

    int checks   = 0;
    int failures = 0;
    int cnt;

    rf_mp u_dut (
        .clk        (clk),
        .rst        (rst),
        .clr_req    (clr_req),
        .busy       (busy),
        .rf_ra      (rf_ra),
        .rf_rd      (rf_rd),
        .rf_wa      (rf_wa),
        .rf_we      (rf_we),
        .rf_wd      (rf_wd),
        .dbg_reg_ra (dbg_reg_ra),
        .dbg_reg_rd (dbg_reg_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [4:0]  dra;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [31:0] ed;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                         input logic [4:0] wa1, input logic [31:0] wd1,
                         input logic [4:0] ra0, input logic [4:0] ra1, input logic [4:0] dra);
        rf_we      = we;
        rf_wa      = {wa1, wa0};
        rf_wd      = {wd1, wd0};
        rf_ra      = {ra1, ra0};
        dbg_reg_ra = dra;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until busy falls, checking reads stay masked; bounded.
    task automatic count_sweep(output int n);
        n = 0;
        while (busy && n < 100) begin
            chk("sweep_rd0_zero", rf_rd[31:0], 32'h0);
            @(posedge clk);
            #1;
            clr_req = 1'b0;
            #1;
            n++;
        end
    endtask

    initial begin
        vecs[0] = '{2'b11, 5'd3,  32'h11111111, 5'd7, 32'h22222222, 5'd5,  5'd6,  5'd0,  32'h0,        32'h0,        32'h0};
        vecs[1] = '{2'b11, 5'd9,  32'hAAAA0000, 5'd9, 32'h0000BBBB, 5'd3,  5'd7,  5'd3,  32'h11111111, 32'h22222222, 32'h11111111};
        vecs[2] = '{2'b01, 5'd0,  32'hFFFFFFFF, 5'd0, 32'h0,        5'd0,  5'd9,  5'd0,  32'h0,        32'h0000BBBB, 32'h0};
        vecs[3] = '{2'b10, 5'd0,  32'h0,        5'd0, 32'hFFFFFFFF, 5'd0,  5'd3,  5'd9,  32'h0,        32'h11111111, 32'h0000BBBB};
        vecs[4] = '{2'b01, 5'd10, 32'hCAFEF00D, 5'd0, 32'h0,        5'd0,  5'd9,  5'd7,  32'h0,        32'h0000BBBB, 32'h22222222};
        vecs[5] = '{2'b00, 5'd0,  32'h0,        5'd0, 32'h0,        5'd10, 5'd31, 5'd10, 32'hCAFEF00D, 32'h0,        32'hCAFEF00D};
        vecs[6] = '{2'b11, 5'd31, 32'h5A5A5A5A, 5'd1, 32'h0F0F0F0F, 5'd10, 5'd7,  5'd1,  32'hCAFEF00D, 32'h22222222, 32'h0};
        vecs[7] = '{2'b00, 5'd0,  32'h0,        5'd0, 32'h0,        5'd31, 5'd1,  5'd31, 32'h5A5A5A5A, 32'h0F0F0F0F, 32'h5A5A5A5A};

        // Reset: outputs defined and masked.
        rst     = 1'b1;
        clr_req = 1'b0;
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd6, 5'd5);
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'h1);
        chk("rst_rd0", rf_rd[31:0], 32'h0);
        chk("rst_rd1", rf_rd[63:32], 32'h0);
        chk("rst_dbg", dbg_reg_rd, 32'h0);

        // Release reset with writes to x5 attempted throughout the sweep.
        rst = 1'b0;
        drive(2'b11, 5'd5, 32'h0000DEAD, 5'd5, 32'h0000DEAD, 5'd5, 5'd5, 5'd5);
        #1;
        count_sweep(cnt);
        chk("rst_sweep_len", 32'(cnt), 32'd32);
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5);
        #1;
        chk("sweep_write_lost_rd", rf_rd[31:0], 32'h0);
        chk("sweep_write_lost_dbg", dbg_reg_rd, 32'h0);
        chk("idle_busy", 32'(busy), 32'h0);
        tick();

        // Table: dual write, conflict, zero register, plain reads.
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].we, vecs[i].wa0, vecs[i].wd0, vecs[i].wa1, vecs[i].wd1,
                  vecs[i].ra0, vecs[i].ra1, vecs[i].dra);
            #1;
            chk($sformatf("vec%0d_rd0", i), rf_rd[31:0], vecs[i].e0);
            chk($sformatf("vec%0d_rd1", i), rf_rd[63:32], vecs[i].e1);
            chk($sformatf("vec%0d_dbg", i), dbg_reg_rd, vecs[i].ed);
            tick();
        end

        // Same-cycle write/read of x4.
        drive(2'b01, 5'd4, 32'h12345678, 5'd0, 32'h0, 5'd4, 5'd0, 5'd4);
        #1;
`ifdef RF_BYPASS_EN
        chk("byp_same_cycle", rf_rd[31:0], 32'h12345678);
`else
        chk("byp_same_cycle", rf_rd[31:0], 32'h0);
`endif
        chk("byp_dbg_same_cycle", dbg_reg_rd, 32'h0);
        tick();
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd4, 5'd0, 5'd4);
        #1;
        chk("byp_next_cycle", rf_rd[31:0], 32'h12345678);
        chk("byp_dbg_next_cycle", dbg_reg_rd, 32'h12345678);
        tick();

        // Conflicting writes to x12 seen on read port 1 in the write cycle.
        drive(2'b11, 5'd12, 32'hAAAA0000, 5'd12, 32'h0000BBBB, 5'd0, 5'd12, 5'd12);
        #1;
`ifdef RF_BYPASS_EN
        chk("byp_conflict", rf_rd[63:32], 32'h0000BBBB);
`else
        chk("byp_conflict", rf_rd[63:32], 32'h0);
`endif
        tick();
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd12, 5'd12);
        #1;
        chk("conflict_stored", rf_rd[63:32], 32'h0000BBBB);
        tick();

        // clr_req sweep with a second pulse mid-sweep that must be ignored.
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        #1;
        chk("clr_busy", 32'(busy), 32'h1);
        cnt = 0;
        while (busy && cnt < 100) begin
            if (cnt == 5) clr_req = 1'b1;
            @(posedge clk);
            #1;
            clr_req = 1'b0;
            #1;
            cnt++;
        end
        chk("clr_sweep_len", 32'(cnt), 32'd32);
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd31, 5'd10);
        #1;
        chk("clr_x3", rf_rd[31:0], 32'h0);
        chk("clr_x31", rf_rd[63:32], 32'h0);
        chk("clr_x10_dbg", dbg_reg_rd, 32'h0);
        tick();

        // Reset in the middle of a sweep restarts it from entry 0.
        drive(2'b01, 5'd20, 32'h20202020, 5'd0, 32'h0, 5'd20, 5'd0, 5'd20);
        tick();
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd20, 5'd0, 5'd20);
        #1;
        chk("pre_rst_x20", rf_rd[31:0], 32'h20202020);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midsweep_rst_busy", 32'(busy), 32'h1);
        chk("midsweep_rst_rd", rf_rd[31:0], 32'h0);
        tick();
        rst = 1'b0;
        #1;
        count_sweep(cnt);
        chk("rst_restart_len", 32'(cnt), 32'd32);
        chk("post_restart_x20", rf_rd[31:0], 32'h0);
        chk("post_restart_dbg", dbg_reg_rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
